// File: rtl/filt_quant_dec_pkg.sv
// Shared helpers for filt_quant_dec: saturation limits and FIFO pointer sizing.
package filt_quant_dec_pkg;

    localparam int unsigned FIFO_DEPTH_DEFAULT = 4;

    // Pointer width: address bits plus one wrap bit that separates full from empty.
    function automatic int unsigned fifo_ptr_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    // Pointer type for the default depth; the FIFO derives its own from its parameter.
    typedef logic [fifo_ptr_width(FIFO_DEPTH_DEFAULT)-1:0] fifo_ptr_t;

    // Largest value representable in a signed word of oup_width bits.
    function automatic logic signed [63:0] sat_max(input int unsigned oup_width);
        return (64'sd1 <<< (oup_width - 1)) - 64'sd1;
    endfunction

    // Smallest value representable in a signed word of oup_width bits.
    function automatic logic signed [63:0] sat_min(input int unsigned oup_width);
        return -(64'sd1 <<< (oup_width - 1));
    endfunction

endpackage

// File: rtl/filt_quant_dec_fifo.sv
// Show-ahead synchronous FIFO. Head entry is visible on o_data while not empty;
// a push into a full FIFO succeeds only when a pop happens on the same edge.
module filt_quant_dec_fifo
    import filt_quant_dec_pkg::*;
#(
    parameter int unsigned gp_width = 16,
    parameter int unsigned gp_depth = 4
) (
    input  logic                i_clk,
    input  logic                i_rst_an,
    input  logic                i_push,
    input  logic [gp_width-1:0] i_data,
    input  logic                i_pop,
    output logic [gp_width-1:0] o_data,
    output logic                o_full,
    output logic                o_empty
);

    localparam int unsigned PW = fifo_ptr_width(gp_depth);
    localparam int unsigned AW = PW - 1;

    typedef logic [PW-1:0] ptr_t;

    ptr_t                wr_ptr_q, wr_ptr_d;
    ptr_t                rd_ptr_q, rd_ptr_d;
    logic [gp_width-1:0] mem_q [gp_depth];
    logic                do_push;
    logic                do_pop;

    assign o_empty = (wr_ptr_q == rd_ptr_q);
    assign o_full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign do_pop  = i_pop && !o_empty;
    assign do_push = i_push && (!o_full || do_pop);

    // Empty FIFO presents zero so the output is clean straight out of reset.
    assign o_data = o_empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    // Pointer advance; the extra MSB toggles on each wrap.
    always_comb begin
        wr_ptr_d = wr_ptr_q + ptr_t'(do_push);
        rd_ptr_d = rd_ptr_q + ptr_t'(do_pop);
    end

    // Pointer registers.
    always_ff @(posedge i_clk or negedge i_rst_an) begin
        if (!i_rst_an) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array, written at the write pointer.
    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= i_data;
        end
    end

endmodule

// File: rtl/filt_quant_dec.sv
// Decimating requantiser behind the MAC: keeps one of every gp_dec_factor
// results, shifts/saturates it to gp_oup_width bits and queues it in a FIFO.
// Build option: define FILT_QUANT_DEC_ROUND_EN for round-half-up, otherwise
// the shift truncates toward minus infinity.
module filt_quant_dec
    import filt_quant_dec_pkg::*;
#(
    parameter int unsigned gp_inp_width  = 37,
    parameter int unsigned gp_oup_width  = 16,
    parameter int unsigned gp_shift      = 20,
    parameter int unsigned gp_dec_factor = 4,
    parameter int unsigned gp_fifo_depth = 4
) (
    input  logic                           i_clk,
    input  logic                           i_rst_an,
    input  logic                           i_ena,
    input  logic signed [gp_inp_width-1:0] i_data,
    input  logic                           i_valid,
    output logic signed [gp_oup_width-1:0] o_data,
    output logic                           o_valid,
    input  logic                           i_ready,
    output logic                           o_sat,
    output logic                           o_ovf
);

    localparam int unsigned W1 = gp_inp_width + 1;
    localparam int unsigned CW = (gp_dec_factor > 1) ? $clog2(gp_dec_factor) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(gp_dec_factor - 1);
    localparam logic signed [W1-1:0] SAT_HI = W1'(sat_max(gp_oup_width));
    localparam logic signed [W1-1:0] SAT_LO = W1'(sat_min(gp_oup_width));
`ifdef FILT_QUANT_DEC_ROUND_EN
    localparam logic signed [W1-1:0] RND_OFS = W1'(1) <<< (gp_shift - 1);
`endif

    logic [CW-1:0]                dec_cnt_q, dec_cnt_d;
    logic                         s1_vld_q, s1_vld_d;
    logic signed [W1-1:0]         s1_val_q, s1_val_d;
    logic                         sat_q, sat_d;
    logic                         ovf_q, ovf_d;
    logic                         accept;
    logic                         keep;
    logic signed [W1-1:0]         ext_val;
    logic signed [W1-1:0]         rnd_val;
    logic signed [gp_oup_width-1:0] s2_val;
    logic [gp_oup_width-1:0]      fifo_dout;
    logic                         s2_clip;
    logic                         fifo_push;
    logic                         fifo_full;
    logic                         fifo_empty;
    logic                         wr_ok;

    assign accept = i_valid && i_ena;
    assign keep   = accept && (dec_cnt_q == '0);

    // Decimation counter and stage-1 arithmetic: extend, optional round offset, shift.
    always_comb begin
        dec_cnt_d = dec_cnt_q;
        if (!i_ena) begin
            dec_cnt_d = '0;
        end else if (accept) begin
            dec_cnt_d = (dec_cnt_q == CNT_LAST) ? '0 : dec_cnt_q + CW'(1);
        end
        ext_val = W1'(i_data);
`ifdef FILT_QUANT_DEC_ROUND_EN
        rnd_val = ext_val + RND_OFS;
`else
        rnd_val = ext_val;
`endif
        s1_vld_d = keep;
        s1_val_d = keep ? (rnd_val >>> gp_shift) : s1_val_q;
    end

    // Stage 2: clip to the output range; the FIFO write itself is the register.
    always_comb begin
        s2_clip = 1'b0;
        s2_val  = s1_val_q[gp_oup_width-1:0];
        if (s1_val_q > SAT_HI) begin
            s2_clip = 1'b1;
            s2_val  = SAT_HI[gp_oup_width-1:0];
        end else if (s1_val_q < SAT_LO) begin
            s2_clip = 1'b1;
            s2_val  = SAT_LO[gp_oup_width-1:0];
        end
    end

    // A full FIFO holds at least one entry, so a pop is guaranteed when i_ready is high.
    assign fifo_push = s1_vld_q && i_ena;
    assign wr_ok     = fifo_push && (!fifo_full || i_ready);

    // Flag next-state: sat pulses with an accepted clipped write; ovf is sticky until disable.
    always_comb begin
        sat_d = wr_ok && s2_clip;
        ovf_d = ovf_q;
        if (!i_ena) begin
            ovf_d = 1'b0;
        end else if (fifo_push && fifo_full && !i_ready) begin
            ovf_d = 1'b1;
        end
    end

    // Pipeline and flag registers.
    always_ff @(posedge i_clk or negedge i_rst_an) begin
        if (!i_rst_an) begin
            dec_cnt_q <= '0;
            s1_vld_q  <= 1'b0;
            s1_val_q  <= '0;
            sat_q     <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            dec_cnt_q <= dec_cnt_d;
            s1_vld_q  <= s1_vld_d;
            s1_val_q  <= s1_val_d;
            sat_q     <= sat_d;
            ovf_q     <= ovf_d;
        end
    end

    filt_quant_dec_fifo #(
        .gp_width (gp_oup_width),
        .gp_depth (gp_fifo_depth)
    ) u_fifo (
        .i_clk    (i_clk),
        .i_rst_an (i_rst_an),
        .i_push   (fifo_push),
        .i_data   (s2_val),
        .i_pop    (i_ready),
        .o_data   (fifo_dout),
        .o_full   (fifo_full),
        .o_empty  (fifo_empty)
    );

    assign o_data  = fifo_dout;
    assign o_valid = !fifo_empty;
    assign o_sat   = sat_q;
    assign o_ovf   = ovf_q;

endmodule

// File: tb/tb_filt_quant_dec.sv
`timescale 1ns/1ps
module tb_filt_quant_dec;

    localparam logic signed [36:0] P19 = 37'sd524288;
    localparam logic signed [36:0] N19 = -37'sd524288;
    localparam logic signed [36:0] P35 = 37'sh08_0000_0000;
    localparam logic signed [36:0] N36 = 37'sh10_0000_0000;
`ifdef FILT_QUANT_DEC_ROUND_EN
    localparam logic signed [15:0] R_POS = 16'sd1;
    localparam logic signed [15:0] R_NEG = 16'sd0;
`else
    localparam logic signed [15:0] R_POS = 16'sd0;
    localparam logic signed [15:0] R_NEG = -16'sd1;
`endif

    logic              clk = 1'b0;
    logic              rst_an = 1'b0;
    logic              ena = 1'b0;
    logic              vld = 1'b0;
    logic              rdy = 1'b0;
    logic signed [36:0] din = '0;
    logic signed [15:0] dout;
    logic              ovalid;
    logic              osat;
    logic              oovf;

    int n_cmp = 0;
    int n_bad = 0;
    logic signed [15:0] exp_q[$];

    always #5 clk = ~clk;

    filt_quant_dec dut (
        .i_clk    (clk),
        .i_rst_an (rst_an),
        .i_ena    (ena),
        .i_data   (din),
        .i_valid  (vld),
        .o_data   (dout),
        .o_valid  (ovalid),
        .i_ready  (rdy),
        .o_sat    (osat),
        .o_ovf    (oovf)
    );

    function automatic logic signed [36:0] s20(input int k);
        logic signed [36:0] v;
        v = 37'(k);
        return v <<< 20;
    endfunction

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    // Drive one valid input for one edge; queue its expected output if it should reach the FIFO.
    task automatic feed(input logic signed [36:0] d, input bit push, input logic signed [15:0] e);
        din = d;
        vld = 1'b1;
        if (push) exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic feed_k(input int k, input bit push);
        feed(s20(k), push, 16'(k));
    endtask

    task automatic pad(input int n);
        repeat (n) feed('0, 1'b0, '0);
    endtask

    task automatic idle(input int n);
        vld = 1'b0;
        din = '0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Scoreboard monitor: every handshake pops the oldest expected word.
    always @(negedge clk) begin
        if (rst_an && ovalid && rdy) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL out_unexpected: got %0d, required no output", dout);
            end else begin
                logic signed [15:0] e;
                e = exp_q.pop_front();
                if (dout !== e) begin
                    n_bad++;
                    $display("FAIL out_data: got %0d, required %0d", dout, e);
                end else begin
                    $display("ok   out_data: %0d", dout);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        #2;
        chk("rst_data", dout, 0);
        chk("rst_valid", ovalid, 0);
        chk("rst_sat", osat, 0);
        chk("rst_ovf", oovf, 0);
        @(posedge clk);
        #1;
        rst_an = 1'b1;
        ena = 1'b1;
        rdy = 1'b1;
        idle(2);

        // Rounding: first sample of each group of four is kept.
        feed(P19, 1'b1, R_POS); pad(3);
        feed(N19, 1'b1, R_NEG); pad(3);
        idle(4);

        // Decimation and first-output latency.
        feed_k(1, 1'b1);
        chk("dec_valid_after_t", ovalid, 0);
        feed_k(2, 1'b0);
        chk("dec_valid_after_t1", ovalid, 1);
        feed_k(3, 1'b0); feed_k(4, 1'b0);
        feed_k(5, 1'b1);
        feed_k(6, 1'b0); feed_k(7, 1'b0); feed_k(8, 1'b0);
        idle(4);

        // Saturation pulses.
        feed(P35, 1'b1, 16'sd32767); pad(1);
        chk("sat_hi_pulse", osat, 1);
        pad(1);
        chk("sat_hi_end", osat, 0);
        pad(1);
        feed(N36, 1'b1, 16'sh8000); pad(1);
        chk("sat_lo_pulse", osat, 1);
        pad(1);
        chk("sat_lo_end", osat, 0);
        pad(1);
        feed_k(100, 1'b1); pad(1);
        chk("sat_none", osat, 0);
        pad(2);
        idle(4);

        // Overflow: four fit, the fifth is dropped.
        rdy = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            feed_k(k, 1'b1);
            pad(3);
        end
        feed_k(5, 1'b0);
        chk("ovf_before_drop", oovf, 0);
        pad(1);
        chk("ovf_set", oovf, 1);
        chk("ovf_drop_no_sat", osat, 0);
        chk("ovf_full_valid", ovalid, 1);
        pad(2);
        chk("ovf_sticky", oovf, 1);

        // Drain while a sample sits in stage 1, then disable: it must never land.
        rdy = 1'b1;
        feed_k(20, 1'b0);
        ena = 1'b0;
        idle(1);
        chk("ena_ovf_clear", oovf, 0);
        idle(1);
        chk("drain_third_valid", ovalid, 1);
        idle(1);
        chk("drain_empty", ovalid, 0);
        idle(2);
        chk("ena_drop_not_written", ovalid, 0);

        // Re-enable: the first accepted sample is kept.
        ena = 1'b1;
        feed_k(21, 1'b1);
        idle(4);

        // Full plus simultaneous pop loses nothing.
        ena = 1'b0;
        idle(1);
        ena = 1'b1;
        rdy = 1'b0;
        for (int k = 6; k <= 9; k++) begin
            feed_k(k, 1'b1);
            pad(3);
        end
        feed_k(10, 1'b1);
        rdy = 1'b1;
        pad(1);
        chk("fp_no_ovf", oovf, 0);
        chk("fp_valid", ovalid, 1);
        idle(6);
        chk("fp_drained", ovalid, 0);

        // Asynchronous reset mid-stream.
        ena = 1'b0;
        idle(1);
        ena = 1'b1;
        rdy = 1'b0;
        feed(P35, 1'b1, 16'sd32767);
        pad(1);
        chk("pre_rst_sat", osat, 1);
        chk("pre_rst_valid", ovalid, 1);
        #2;
        rst_an = 1'b0;
        #1;
        chk("arst_data", dout, 0);
        chk("arst_valid", ovalid, 0);
        chk("arst_sat", osat, 0);
        chk("arst_ovf", oovf, 0);
        exp_q.delete();
        vld = 1'b0;
        @(posedge clk);
        #1;
        rst_an = 1'b1;
        rdy = 1'b1;
        feed_k(7, 1'b1);
        idle(4);

        for (int i = 0; i < 50 && exp_q.size() > 0; i++) begin
            @(posedge clk);
            #1;
        end
        chk("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/filt_quant_dec.md
# filt_quant_dec

Output stage placed directly downstream of `filt_mac_verilator`. It accepts the wide full-precision MAC result on each `o_done` strobe and decimates by a fixed factor. Each kept sample is rounded, shifted and saturated to a narrow signed word, then buffered in a small FIFO. The FIFO drains to the consumer over a valid/ready handshake, so the filter never stalls.

## Interface
Parameters:
- `gp_inp_width`, default 37: input width; equals the MAC `gp_oup_width` (8+12+17).
- `gp_oup_width`, default 16: output word width.
- `gp_shift`, default 20: number of LSBs discarded. Must satisfy 1 ≤ `gp_shift` < `gp_inp_width`.
- `gp_dec_factor`, default 4: decimation factor, ≥1.
- `gp_fifo_depth`, default 4: FIFO entries, power of 2, ≥2.

Ports (one clock; reset is asynchronous and active-low):
- `i_clk`, in, 1: rising-edge clock.
- `i_rst_an`, in, 1: asynchronous active-low reset.
- `i_ena`, in, 1: block enable.
- `i_data`, in, `gp_inp_width`, signed: MAC result.
- `i_valid`, in, 1: `i_data` is valid. Wired to the MAC `o_done`.
- `o_data`, out, `gp_oup_width`, signed: FIFO head.
- `o_valid`, out, 1: FIFO not empty.
- `i_ready`, in, 1: consumer accepts `o_data`.
- `o_sat`, out, 1: one-cycle pulse that accompanies a FIFO write of a saturated sample.
- `o_ovf`, out, 1: sticky flag; a kept sample was dropped because the FIFO was full.

## Operation
- **Input acceptance.** An input is accepted on an edge where `i_valid && i_ena` is high.
- **Decimation.** Counter `dec_cnt` runs 0..`gp_dec_factor`-1.
  - It increments on each accepted input and wraps to 0.
  - An input is kept only when `dec_cnt` == 0, so the first accepted sample after reset or enable is kept.
- **Stage 1 (registered).** Sign-extend the kept sample to `gp_inp_width`+1 bits, apply the rounding offset (see Configuration), then arithmetic-shift right by `gp_shift`.
- **Stage 2 (registered).** Saturate to the range -2^(`gp_oup_width`-1) .. 2^(`gp_oup_width`-1)-1 and write the result to the FIFO. `o_sat` pulses in the cycle the written entry was clipped.
- **FIFO.**
  - Show-ahead: `o_data` is the head entry and `o_valid` = !empty.
  - A pop occurs on an edge where `o_valid && i_ready`.
- **FIFO boundary cases.**
  - Full with no pop: the incoming write is dropped, `o_ovf` is set to 1 and `o_sat` stays 0.
  - Full with a simultaneous pop: both operations succeed and the count is unchanged.
  - Empty: there is no bypass, and `i_ready` is ignored.
  - Read and write pointers wrap modulo `gp_fifo_depth`. Full is distinguished from empty by an extra pointer bit.
- **Enable low.** When `i_ena` = 0:
  - `dec_cnt` is cleared, stage valid bits are cleared, in-flight samples are discarded and `o_ovf` is cleared.
  - FIFO contents are retained and still drain through the handshake.
- **Reset.** Reset may assert at any time and asynchronously clears:
  - all pipeline registers, pointers and `dec_cnt`;
  - the outputs: `o_data` = 0, `o_valid` = 0, `o_sat` = 0, `o_ovf` = 0.

## Timing
- An input accepted at edge t is captured by stage 1 at edge t and written to the FIFO at edge t+1. `o_valid` is high after edge t+1, giving 2 cycles from input to output on an empty FIFO.
- Sustained throughput: one kept sample per cycle in, and one word per cycle out while `i_ready` is high.
- `o_sat` is high during the cycle after the write edge, for one cycle.
- `o_ovf` is set after the dropping edge and holds until reset or `i_ena` goes low.
- `o_data` and `o_valid` change only on clock edges. They are a function of FIFO state only and have no combinational path from `i_ready`.

## Configuration
Macro: `FILT_QUANT_DEC_ROUND_EN`.
- Defined: round half up. 2^(`gp_shift`-1) is added before the shift.
- Undefined: truncation toward -∞ (plain arithmetic shift); the adder is removed.
- Latency and all other behaviour are identical in both cases.

## Structure
- Package `filt_quant_dec_pkg` holds:
  - a function computing the saturation limits from `gp_oup_width`;
  - a typedef for the FIFO pointer width, defined as $clog2(`gp_fifo_depth`)+1.
- Sub-module `filt_quant_dec_fifo`: parameterised show-ahead synchronous FIFO. It has push/pop, full/empty outputs and the asynchronous active-low reset.
- The top level contains the decimation counter, the two arithmetic stages and the overflow/saturation flags.

## Test plan
All scenarios use the defaults unless noted.
- **Rounding.** Apply `i_data` = 2^19 with `gp_dec_factor` = 1.
  - With `FILT_QUANT_DEC_ROUND_EN`: `o_data` = 1.
  - Without it: `o_data` = 0.
  - Apply `i_data` = -2^19: `o_data` = 0 with rounding, -1 without.
- **Decimation.** Apply inputs k·2^20 for k = 1..8 on consecutive `i_valid` cycles with `i_ready` = 1. Required: the outputs are exactly 1 and 5, and `o_valid` first goes high 2 cycles after the k = 1 input.
- **Saturation.**
  - `i_data` = 2^35 gives `o_data` = 32767 with a one-cycle `o_sat` pulse.
  - `i_data` = -2^36 gives -32768 with an `o_sat` pulse.
  - `i_data` = 100·2^20 gives 100 with `o_sat` = 0.
- **Overflow.** Hold `i_ready` = 0 and feed 5 kept samples, values 1..5 (×2^20). Required:
  - `o_ovf` = 1 after the 5th write attempt;
  - draining then yields 1, 2, 3, 4, with `o_valid` dropping after the 4th pop;
  - a full-plus-pop case on the same edge loses no data.
- **Enable and reset mid-stream.**
  - Drop `i_ena` while a sample is in stage 1: the sample is never written, the FIFO still drains and `o_ovf` is cleared.
  - Assert `i_rst_an` = 0 mid-stream: all outputs go to 0 immediately, without waiting for a clock edge.
  - On re-enable, the first accepted sample is kept.
